// File: rtl/phys_mem_pkg.sv
// Shared definitions for the physical memory endpoint and related bus endpoints:
// MMIO register offsets, address region and FSM state types, default poison word.
package phys_mem_pkg;

  // Byte offsets of the MMIO registers inside the MMIO window (low two bits ignored)
  localparam logic [15:0] MMIO_OFF_PTBASE      = 16'h0000;
  localparam logic [15:0] MMIO_OFF_READ_COUNT  = 16'h0004;
  localparam logic [15:0] MMIO_OFF_WRITE_COUNT = 16'h0008;
  localparam logic [15:0] MMIO_OFF_FAULT_ADDR  = 16'h000C;
  localparam logic [15:0] MMIO_OFF_WP_LIMIT    = 16'h0010;

  // Read data returned for unmapped accesses and for reads issued while clearing
  localparam logic [31:0] POISON_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    REGION_RAM      = 2'd0,
    REGION_MMIO     = 2'd1,
    REGION_UNMAPPED = 2'd2
  } region_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Saturating 32-bit increment used by the access counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/phys_mem_decode.sv
// Combinational address decoder: classifies a byte address into RAM, MMIO or
// unmapped and extracts the RAM word index and the word-aligned MMIO offset.
module phys_mem_decode
  import phys_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic [31:0]   addr,
  output region_e       region,
  output logic [AW-1:0] ram_idx,
  output logic [15:0]   mmio_off
);

  // RAM size in bytes, one bit wider than the address so DEPTH*4 never wraps
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  // Region select; RAM takes priority should the two windows ever overlap
  always_comb begin
    region   = REGION_UNMAPPED;
    ram_idx  = addr[AW+1:2];
    mmio_off = {addr[15:2], 2'b00};
    if ({1'b0, addr} < RAM_BYTES) begin
      region = REGION_RAM;
    end else if (addr[31:16] == MMIO_BASE[31:16]) begin
      region = REGION_MMIO;
    end else begin
      region = REGION_UNMAPPED;
    end
  end

endmodule

// File: rtl/phys_mem_port.sv
// Physical memory endpoint behind the memory controller's physical port.
// Holds the word RAM, a small MMIO register window (page-table base, access
// counters, first fault address) and a sequencer that zeroes the RAM after reset.
// Optional build macro: PHYS_MEM_WRITE_PROTECT_EN adds the WP_LIMIT register
// and drops RAM writes below that byte address, flagging them as faults.
module phys_mem_port
  import phys_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter logic [31:0] PT_RESET  = 32'h0000_8000,
  parameter logic [31:0] POISON    = POISON_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] phRamAddress,
  input  logic [31:0] phRamOut,
  input  logic        phRequest,
  input  logic        phWriteEnable,
  output logic [31:0] phRamIn,
  output logic [31:0] ptAddress,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned  AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [31:0]   mem_r [DEPTH];

  state_e        state_r;
  state_e        state_next_s;
  logic [AW-1:0] clear_idx_r;
  logic          busy_r;
  logic          fault_r;
  logic [31:0]   ph_ram_in_r;
  logic [31:0]   pt_base_r;
  logic [31:0]   rd_count_r;
  logic [31:0]   wr_count_r;
  logic [31:0]   fault_addr_r;

  region_e       region_s;
  logic [AW-1:0] ram_idx_s;
  logic [15:0]   mmio_off_s;

  logic          rd_acc_s;
  logic          wr_acc_s;
  logic          clear_rd_s;
  logic          wp_hit_s;
  logic          fault_evt_s;
  logic          pt_we_s;
  logic [31:0]   mmio_rdata_s;
  logic [31:0]   rd_data_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_widx_s;
  logic [31:0]   mem_wdata_s;

`ifdef PHYS_MEM_WRITE_PROTECT_EN
  logic [31:0]   wp_limit_r;
  logic          wp_we_s;
`endif

  phys_mem_decode #(
    .DEPTH     (DEPTH),
    .MMIO_BASE (MMIO_BASE)
  ) u_decode (
    .addr     (phRamAddress),
    .region   (region_s),
    .ram_idx  (ram_idx_s),
    .mmio_off (mmio_off_s)
  );

  // Next state: CLEAR walks every word once, READY is left only through reset
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clear_idx_r == LAST_IDX) begin
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_READY: state_next_s = ST_READY;
      default:  state_next_s = ST_CLEAR;
    endcase
  end

  // State register; busy mirrors the state it will be in after this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_CLEAR;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_CLEAR);
    end
  end

  // Request qualification: only READY accepts; reads during CLEAR get poison
  always_comb begin
    rd_acc_s   = phRequest && !phWriteEnable && (state_r == ST_READY);
    wr_acc_s   = phRequest &&  phWriteEnable && (state_r == ST_READY);
    clear_rd_s = phRequest && !phWriteEnable && (state_r == ST_CLEAR);
    pt_we_s    = wr_acc_s && (region_s == REGION_MMIO) && (mmio_off_s == MMIO_OFF_PTBASE);
  end

`ifdef PHYS_MEM_WRITE_PROTECT_EN
  // Write-protect hit: RAM write below the programmed byte limit
  always_comb begin
    wp_hit_s = wr_acc_s && (region_s == REGION_RAM) && (phRamAddress < wp_limit_r);
    wp_we_s  = wr_acc_s && (region_s == REGION_MMIO) && (mmio_off_s == MMIO_OFF_WP_LIMIT);
  end
`else
  // Without write protection no RAM write is ever blocked
  always_comb begin
    wp_hit_s = 1'b0;
  end
`endif

  // Fault event: any accepted access outside the map, or a protected RAM write
  always_comb begin
    fault_evt_s = (rd_acc_s || wr_acc_s) && ((region_s == REGION_UNMAPPED) || wp_hit_s);
  end

  // MMIO read mux; unused offsets read as zero
  always_comb begin
    mmio_rdata_s = 32'h0000_0000;
    case (mmio_off_s)
      MMIO_OFF_PTBASE:      mmio_rdata_s = pt_base_r;
      MMIO_OFF_READ_COUNT:  mmio_rdata_s = rd_count_r;
      MMIO_OFF_WRITE_COUNT: mmio_rdata_s = wr_count_r;
      MMIO_OFF_FAULT_ADDR:  mmio_rdata_s = fault_addr_r;
`ifdef PHYS_MEM_WRITE_PROTECT_EN
      MMIO_OFF_WP_LIMIT:    mmio_rdata_s = wp_limit_r;
`endif
      default:              mmio_rdata_s = 32'h0000_0000;
    endcase
  end

  // Read data select by region
  always_comb begin
    rd_data_s = POISON;
    case (region_s)
      REGION_RAM:  rd_data_s = mem_r[ram_idx_s];
      REGION_MMIO: rd_data_s = mmio_rdata_s;
      default:     rd_data_s = POISON;
    endcase
  end

  // RAM write port shared by the clear sequencer and accepted RAM writes
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = clear_idx_r;
    mem_wdata_s = 32'h0000_0000;
    if (state_r == ST_CLEAR) begin
      mem_we_s = 1'b1;
    end else if (wr_acc_s && (region_s == REGION_RAM) && !wp_hit_s) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = ram_idx_s;
      mem_wdata_s = phRamOut;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // RAM array; contents survive reset and are zeroed by the clear sequencer
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Clear index advances once per CLEAR cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clear_idx_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      clear_idx_r <= clear_idx_r + IDX_ONE;
    end
  end

  // Registered read data, held until the next read request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_ram_in_r <= 32'h0000_0000;
    end else if (rd_acc_s) begin
      ph_ram_in_r <= rd_data_s;
    end else if (clear_rd_s) begin
      ph_ram_in_r <= POISON;
    end
  end

  // Saturating access counters; a counter read sees the pre-increment value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count_r <= 32'h0000_0000;
      wr_count_r <= 32'h0000_0000;
    end else begin
      if (rd_acc_s) begin
        rd_count_r <= sat_inc32(rd_count_r);
      end
      if (wr_acc_s) begin
        wr_count_r <= sat_inc32(wr_count_r);
      end
    end
  end

  // Page-table base register feeding the controller's page walker
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pt_base_r <= PT_RESET;
    end else if (pt_we_s) begin
      pt_base_r <= phRamOut;
    end
  end

  // Sticky fault flag; only the first faulting address is captured
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_r      <= 1'b0;
      fault_addr_r <= 32'h0000_0000;
    end else if (fault_evt_s) begin
      fault_r <= 1'b1;
      if (!fault_r) begin
        fault_addr_r <= phRamAddress;
      end
    end
  end

`ifdef PHYS_MEM_WRITE_PROTECT_EN
  // Write-protect limit register, programmed through MMIO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_limit_r <= 32'h0000_0000;
    end else if (wp_we_s) begin
      wp_limit_r <= phRamOut;
    end
  end
`endif

  assign phRamIn   = ph_ram_in_r;
  assign ptAddress = pt_base_r;
  assign busy      = busy_r;
  assign fault     = fault_r;

endmodule

// File: tb/tb_phys_mem_port.sv
// Self-checking bench for phys_mem_port: directed steps plus a randomized
// phase, all compared against a behavioural model of the endpoint.
module tb_phys_mem_port;

  localparam int unsigned DEPTH  = 1024;
  localparam logic [31:0] MMIO   = 32'hFFFF_0000;
  localparam logic [31:0] PT_RST = 32'h0000_8000;
  localparam logic [31:0] POIS   = 32'hDEAD_BEEF;
`ifdef PHYS_MEM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] phRamAddress = 32'h0;
  logic [31:0] phRamOut = 32'h0;
  logic        phRequest = 1'b0;
  logic        phWriteEnable = 1'b0;
  logic [31:0] phRamIn;
  logic [31:0] ptAddress;
  logic        busy;
  logic        fault;

  int checks = 0;
  int failures = 0;
  int edges_since_rel = 0;

  // Behavioural model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rd_data;
  logic [31:0] m_pt;
  logic [31:0] m_rdc;
  logic [31:0] m_wrc;
  logic [31:0] m_faddr;
  logic [31:0] m_wp;
  logic        m_fault;

  phys_mem_port #(
    .DEPTH     (DEPTH),
    .MMIO_BASE (MMIO),
    .PT_RESET  (PT_RST),
    .POISON    (POIS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .phRamAddress  (phRamAddress),
    .phRamOut      (phRamOut),
    .phRequest     (phRequest),
    .phWriteEnable (phWriteEnable),
    .phRamIn       (phRamIn),
    .ptAddress     (ptAddress),
    .busy          (busy),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_rd_data = 32'h0;
    m_pt      = PT_RST;
    m_rdc     = 32'h0;
    m_wrc     = 32'h0;
    m_faddr   = 32'h0;
    m_wp      = 32'h0;
    m_fault   = 1'b0;
  endtask

  task automatic model_fault(input logic [31:0] a);
    if (!m_fault) m_faddr = a;
    m_fault = 1'b1;
  endtask

  // Apply one access to the model; the device is READY once DEPTH edges have passed
  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    int idx;
    if (edges_since_rel < DEPTH) begin
      if (!we) m_rd_data = POIS;
    end else begin
      idx = int'(a >> 2);
      off = a & 32'h0000_FFFC;
      if (a < 32'(DEPTH * 4)) begin
        if (we) begin
          if (WP_EN && (a < m_wp)) model_fault(a);
          else m_mem[idx] = d;
        end else begin
          m_rd_data = m_mem[idx];
        end
      end else if (a[31:16] == MMIO[31:16]) begin
        if (we) begin
          if (off == 32'h0) m_pt = d;
          else if (WP_EN && (off == 32'h10)) m_wp = d;
        end else begin
          case (off)
            32'h0:   m_rd_data = m_pt;
            32'h4:   m_rd_data = m_rdc;
            32'h8:   m_rd_data = m_wrc;
            32'hC:   m_rd_data = m_faddr;
            32'h10:  m_rd_data = WP_EN ? m_wp : 32'h0;
            default: m_rd_data = 32'h0;
          endcase
        end
      end else begin
        if (!we) m_rd_data = POIS;
        model_fault(a);
      end
      if (we) m_wrc = sat(m_wrc);
      else    m_rdc = sat(m_rdc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (reset) edges_since_rel++;
  endtask

  // One request strobe, driven at a negedge and accepted on the following posedge
  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d);
    phRequest     = 1'b1;
    phWriteEnable = we;
    phRamAddress  = a;
    phRamOut      = d;
    model_access(we, a, d);
    tick();
    phRequest     = 1'b0;
    phWriteEnable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    phRequest = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_phRamIn", phRamIn, 32'h0);
    chk("rst_ptAddress", ptAddress, PT_RST);
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    reset = 1'b1;
    edges_since_rel = 0;
  endtask

  // Busy must be high through DEPTH-1 edges after release and low after DEPTH
  task automatic wait_clear();
    while (edges_since_rel < DEPTH - 1) tick();
    chk("busy_last_clear", {31'h0, busy}, 32'h1);
    tick();
    chk("busy_done", {31'h0, busy}, 32'h0);
  endtask

  task automatic post_checks(input string tag);
    chk({tag, "_rd"}, phRamIn, m_rd_data);
    chk({tag, "_pt"}, ptAddress, m_pt);
    chk({tag, "_fault"}, {31'h0, fault}, {31'h0, m_fault});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    int          k;

    // Clear after power-up reset
    do_reset();
    chk("busy_at_release", {31'h0, busy}, 32'h1);
    wait_clear();
    req(1'b0, 32'h10, 32'h0);
    chk("clear_read", phRamIn, 32'h0);

    // RAM write then read with ignored low address bits
    req(1'b1, 32'h40, 32'h1234_5678);
    chk("write_keeps_rd", phRamIn, 32'h0);
    req(1'b0, 32'h43, 32'h0);
    chk("ram_read", phRamIn, 32'h1234_5678);
    req(1'b0, MMIO + 32'h4, 32'h0);
    chk("read_count", phRamIn, 32'd2);
    req(1'b0, MMIO + 32'h8, 32'h0);
    chk("write_count", phRamIn, 32'd1);

    // Page-table base
    req(1'b1, MMIO, 32'h0002_0000);
    chk("ptaddress_upd", ptAddress, 32'h0002_0000);
    req(1'b0, MMIO + 32'h3, 32'h0);
    chk("ptbase_readback", phRamIn, 32'h0002_0000);
    req(1'b0, MMIO + 32'h4, 32'h0);
    chk("read_count_pre_inc", phRamIn, 32'd5);

    // RO and unused offsets
    req(1'b1, MMIO + 32'h4, 32'h7777_7777);
    req(1'b1, MMIO + 32'h20, 32'h0000_FFFF);
    req(1'b0, MMIO + 32'h20, 32'h0);
    chk("unused_off_read", phRamIn, 32'h0);
    req(1'b0, MMIO + 32'h4, 32'h0);
    chk("ro_write_ignored", phRamIn, m_rd_data);
    chk("no_fault_mmio", {31'h0, fault}, 32'h0);

    // RAM boundaries
    req(1'b1, 32'(DEPTH * 4 - 4), 32'hA5A5_0001);
    req(1'b0, 32'(DEPTH * 4 - 1), 32'h0);
    chk("ram_last_word", phRamIn, 32'hA5A5_0001);
    chk("no_fault_ram", {31'h0, fault}, 32'h0);

    // Unmapped accesses: poison, sticky fault, first address kept
    req(1'b0, 32'h8000_0000, 32'h0);
    chk("unmapped_poison", phRamIn, 32'hDEAD_BEEF);
    chk("unmapped_fault", {31'h0, fault}, 32'h1);
    req(1'b0, MMIO + 32'hC, 32'h0);
    chk("fault_addr", phRamIn, 32'h8000_0000);
    req(1'b1, 32'h9000_0000, 32'h5);
    req(1'b0, MMIO + 32'hC, 32'h0);
    chk("fault_addr_kept", phRamIn, 32'h8000_0000);
    req(1'b0, 32'(DEPTH * 4), 32'h0);
    chk("past_ram_poison", phRamIn, 32'hDEAD_BEEF);
    req(1'b0, MMIO - 32'h4, 32'h0);
    chk("below_mmio_poison", phRamIn, 32'hDEAD_BEEF);

    // Page-walker pattern: strobe, idle, strobe to A+4, idle
    req(1'b1, 32'h200, 32'hC000_0012);
    req(1'b1, 32'h204, 32'h0003_4005);
    req(1'b0, 32'h200, 32'h0);
    chk("walk_pte0", phRamIn, 32'hC000_0012);
    tick();
    chk("walk_pte0_held", phRamIn, 32'hC000_0012);
    req(1'b0, 32'h204, 32'h0);
    chk("walk_pte1", phRamIn, 32'h0003_4005);
    tick();
    chk("walk_pte1_held", phRamIn, 32'h0003_4005);

    // Randomized traffic, back-to-back and spaced
    for (int n = 0; n < 400; n++) begin
      k  = int'($urandom_range(0, 9));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (k < 6)      a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      else if (k < 7) a = $urandom_range(0, DEPTH * 4 - 1);
      else if (k < 9) a = MMIO | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      else            a = 32'h4000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
      if ((a[31:16] == MMIO[31:16]) && ((a & 32'h0000_FFFC) == 32'h10)) d = d & 32'h0000_03FF;
      req(we, a, d);
      post_checks("rand");
      if ($urandom_range(0, 1) == 1) tick();
    end
    req(1'b0, MMIO + 32'h4, 32'h0);
    chk("rand_read_count", phRamIn, m_rd_data);
    req(1'b0, MMIO + 32'h8, 32'h0);
    chk("rand_write_count", phRamIn, m_rd_data);

    // Requests during CLEAR, then reset at clear index 100
    do_reset();
    req(1'b0, 32'h40, 32'h0);
    chk("clear_rd_poison", phRamIn, 32'hDEAD_BEEF);
    req(1'b1, 32'h0, 32'h0000_0055);
    req(1'b1, MMIO, 32'h0000_0001);
    chk("clear_pt_dropped", ptAddress, PT_RST);
    chk("clear_no_fault", {31'h0, fault}, 32'h0);
    while (edges_since_rel < 100) tick();
    chk("busy_mid_clear", {31'h0, busy}, 32'h1);
    do_reset();
    wait_clear();
    req(1'b0, 32'h0, 32'h0);
    chk("cleared_word0", phRamIn, 32'h0);
    req(1'b0, 32'h40, 32'h0);
    chk("cleared_word10", phRamIn, 32'h0);
    req(1'b0, MMIO + 32'h4, 32'h0);
    chk("rst_read_count", phRamIn, 32'd2);
    req(1'b0, MMIO + 32'h8, 32'h0);
    chk("rst_write_count", phRamIn, 32'd0);

    // Write protection (active only when the feature is built in)
    req(1'b1, MMIO + 32'h10, 32'h0000_0100);
    req(1'b1, 32'h80, 32'hAAAA_5555);
    chk("wp_fault", {31'h0, fault}, {31'h0, m_fault});
    req(1'b0, 32'h80, 32'h0);
    chk("wp_ram", phRamIn, m_rd_data);
    req(1'b0, MMIO + 32'h10, 32'h0);
    chk("wp_limit_read", phRamIn, m_rd_data);
    req(1'b1, 32'h100, 32'h0000_1111);
    req(1'b0, 32'h100, 32'h0);
    chk("wp_above_limit", phRamIn, 32'h0000_1111);
    req(1'b0, MMIO + 32'hC, 32'h0);
    chk("wp_fault_addr", phRamIn, m_rd_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
